keypad_guess_entry: RTL and testbench

- Sits directly downstream of the 4x4 keypad row scanner.
- Watches the scanner's row strobe and the raw column lines to debounce whole key presses, then takes the key code from the scanner's held key buffer.
- Assembles a 4-digit, non-repeating decimal guess for the guess-number game core.
- Emits one-cycle key events and a one-cycle guess-submit strobe.

---
 rtl/keypad_guess_entry.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_guess_entry.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_guess_entry.sv
// Keypad guess entry: debounces whole key presses from the 4x4 row scanner and
// assembles a 4-digit, non-repeating BCD guess for the game core.
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   keypadRow         - scanner active-low row strobe (1110,1101,1011,0111)
//   keypadCol         - raw active-low column lines, sampled with keypadRow
//   keypadBuf         - scanner held key code (0-9 digit, a=backspace, b=enter)
//   key_valid         - one-cycle pulse per debounced press
//   key_code          - key code captured with key_valid, held until next press
//   guess             - BCD guess, digit 0 in [15:12]
//   digit_cnt         - number of digits entered (0..4)
//   guess_valid       - one-cycle submit pulse; guess holds the submitted value
//   dup_err           - one-cycle pulse when a repeated digit is rejected
module keypad_guess_entry #(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keypadRow,
  input  logic [3:0]  keypadCol,
  input  logic [3:0]  keypadBuf,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] guess,
  output logic [2:0]  digit_cnt,
  output logic        guess_valid,
  output logic        dup_err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIGITS = 4;
  localparam logic [CNT_W-1:0] FRAMES = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    S_RELEASED  = 2'd0,
    S_PRESSING  = 2'd1,
    S_HELD      = 2'd2,
    S_RELEASING = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dbc_cnt_q, dbc_cnt_d;
  logic              frame_acc_q, frame_acc_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [15:0]       guess_q, guess_d;
  logic [2:0]        digit_cnt_q, digit_cnt_d;
  logic              guess_valid_q, guess_valid_d;
  logic              dup_err_q, dup_err_d;

  logic legal_row;
  logic key_sample;
  logic frame_end;
  logic frame_down;
  logic fire;
  logic dup_hit;

  // Illegal row strobes count as "no key" for the whole sample.
  always_comb begin
    legal_row = 1'b0;
    case (keypadRow)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal_row = 1'b1;
      default:                            legal_row = 1'b0;
    endcase
    key_sample  = legal_row && (keypadCol != 4'b1111);
    frame_end   = (keypadRow == 4'b0111);
    frame_down  = frame_acc_q | key_sample;
    frame_acc_d = frame_end ? 1'b0 : frame_down;
  end

  // Debounce FSM: only advances on the last row of each scan frame.
  always_comb begin
    state_d   = state_q;
    dbc_cnt_d = dbc_cnt_q;
    fire      = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_RELEASED: begin
          if (frame_down) begin
            if (FRAMES <= CNT_W'(1)) begin
              state_d   = S_HELD;
              dbc_cnt_d = '0;
              fire      = 1'b1;
            end else begin
              state_d   = S_PRESSING;
              dbc_cnt_d = CNT_W'(1);
            end
          end
        end
        S_PRESSING: begin
          if (!frame_down) begin
            state_d   = S_RELEASED;
            dbc_cnt_d = '0;
          end else if (dbc_cnt_q + CNT_W'(1) >= FRAMES) begin
            state_d   = S_HELD;
            dbc_cnt_d = '0;
            fire      = 1'b1;
          end else begin
            dbc_cnt_d = dbc_cnt_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!frame_down) begin
            if (FRAMES <= CNT_W'(1)) begin
              state_d   = S_RELEASED;
              dbc_cnt_d = '0;
            end else begin
              state_d   = S_RELEASING;
              dbc_cnt_d = CNT_W'(1);
            end
          end
        end
        S_RELEASING: begin
          if (frame_down) begin
            state_d   = S_HELD;
            dbc_cnt_d = '0;
          end else if (dbc_cnt_q + CNT_W'(1) >= FRAMES) begin
            state_d   = S_RELEASED;
            dbc_cnt_d = '0;
          end else begin
            dbc_cnt_d = dbc_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = S_RELEASED;
          dbc_cnt_d = '0;
        end
      endcase
    end
    key_valid_d = fire;
    key_code_d  = fire ? keypadBuf : key_code_q;
  end

  // Entry processing on the registered key event; a submit clears one cycle later.
  always_comb begin
    guess_d       = guess_q;
    digit_cnt_d   = digit_cnt_q;
    guess_valid_d = 1'b0;
    dup_err_d     = 1'b0;
    dup_hit       = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((3'(i) < digit_cnt_q) && (guess_q[4*(3-i) +: 4] == key_code_q)) dup_hit = 1'b1;
    end
    if (guess_valid_q) begin
      guess_d     = '0;
      digit_cnt_d = '0;
    end else if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        // A full guess swallows further digits silently, even repeats.
        if (digit_cnt_q < 3'(DIGITS)) begin
          if (dup_hit) begin
            dup_err_d = 1'b1;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (3'(i) == digit_cnt_q) guess_d[4*(3-i) +: 4] = key_code_q;
            end
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end else if (key_code_q == 4'ha) begin
        if (digit_cnt_q != 3'd0) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (3'(i) == digit_cnt_q - 3'd1) guess_d[4*(3-i) +: 4] = 4'd0;
          end
          digit_cnt_d = digit_cnt_q - 3'd1;
        end
      end else if ((key_code_q == 4'hb) && (digit_cnt_q == 3'(DIGITS))) begin
        guess_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RELEASED;
      dbc_cnt_q     <= '0;
      frame_acc_q   <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      guess_q       <= '0;
      digit_cnt_q   <= '0;
      guess_valid_q <= 1'b0;
      dup_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dbc_cnt_q     <= dbc_cnt_d;
      frame_acc_q   <= frame_acc_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      guess_q       <= guess_d;
      digit_cnt_q   <= digit_cnt_d;
      guess_valid_q <= guess_valid_d;
      dup_err_q     <= dup_err_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign guess       = guess_q;
  assign digit_cnt   = digit_cnt_q;
  assign guess_valid = guess_valid_q;
  assign dup_err     = dup_err_q;

endmodule

// File: tb/tb_keypad_guess_entry.sv
// Directed bench for keypad_guess_entry with DEBOUNCE_FRAMES = 2.
// Key code k sits at row index k[3:2] and column index k[1:0] of the keypad.
module tb_keypad_guess_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  keypadRow;
  logic [3:0]  keypadCol;
  logic [3:0]  keypadBuf;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] guess;
  logic [2:0]  digit_cnt;
  logic        guess_valid;
  logic        dup_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          kv_cnt = 0;
  int          gv_cnt = 0;
  int          de_cnt = 0;
  logic [3:0]  last_code = 4'd0;
  logic [15:0] gv_guess = 16'd0;
  logic [15:0] post_guess = 16'hffff;
  logic [2:0]  post_cnt = 3'd7;
  logic        gv_prev = 1'b0;

  keypad_guess_entry #(.DEBOUNCE_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .keypadRow   (keypadRow),
    .keypadCol   (keypadCol),
    .keypadBuf   (keypadBuf),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .guess       (guess),
    .digit_cnt   (digit_cnt),
    .guess_valid (guess_valid),
    .dup_err     (dup_err)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (gv_prev) begin
      post_guess = guess;
      post_cnt   = digit_cnt;
    end
    if (key_valid) begin
      kv_cnt++;
      last_code = key_code;
    end
    if (guess_valid) begin
      gv_cnt++;
      gv_guess = guess;
    end
    if (dup_err) de_cnt++;
    gv_prev = guess_valid;
  end

  function automatic logic [3:0] strobe(input logic [1:0] idx);
    case (idx)
      2'd0:    strobe = 4'b1110;
      2'd1:    strobe = 4'b1101;
      2'd2:    strobe = 4'b1011;
      default: strobe = 4'b0111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One scan frame; down asserts the column of key code in its row.
  task automatic frame(input logic down, input logic [3:0] code);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      keypadRow = strobe(2'(i));
      keypadCol = (down && (2'(i) == code[3:2])) ? strobe(code[1:0]) : 4'b1111;
    end
  endtask

  task automatic press(input logic [3:0] code);
    keypadBuf = code;
    repeat (2) frame(1'b1, code);
    repeat (3) frame(1'b0, code);
  endtask

  int kv0, gv0, de0;

  initial begin
    rst       = 1'b1;
    keypadRow = 4'b1110;
    keypadCol = 4'b1111;
    keypadBuf = 4'd0;
    #1;
    check("reset_key_valid", 16'(key_valid), 16'd0);
    check("reset_guess", guess, 16'h0000);
    check("reset_digit_cnt", 16'(digit_cnt), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frame(1'b0, 4'd0);

    // Single press held six frames fires exactly once.
    kv0 = kv_cnt;
    keypadBuf = 4'd5;
    repeat (6) frame(1'b1, 4'd5);
    repeat (3) frame(1'b0, 4'd5);
    check("single_kv_count", 16'(kv_cnt - kv0), 16'd1);
    check("single_key_code", 16'(key_code), 16'd5);
    check("single_guess", guess, 16'h5000);
    check("single_digit_cnt", 16'(digit_cnt), 16'd1);
    press(4'ha);
    check("single_bs_cnt", 16'(digit_cnt), 16'd0);

    // Bounce: down, up, down must not fire.
    kv0 = kv_cnt;
    keypadBuf = 4'd7;
    frame(1'b1, 4'd7);
    frame(1'b0, 4'd7);
    frame(1'b1, 4'd7);
    repeat (3) frame(1'b0, 4'd7);
    check("bounce_no_kv", 16'(kv_cnt - kv0), 16'd0);
    check("bounce_guess", guess, 16'h0000);
    press(4'd7);
    check("bounce_kv_count", 16'(kv_cnt - kv0), 16'd1);
    check("bounce_last_code", 16'(last_code), 16'd7);
    check("bounce_guess7", guess, 16'h7000);
    press(4'ha);

    // Full entry and submit.
    gv0 = gv_cnt;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("entry_guess", guess, 16'h1234);
    check("entry_cnt", 16'(digit_cnt), 16'd4);
    press(4'hb);
    check("entry_gv_count", 16'(gv_cnt - gv0), 16'd1);
    check("entry_gv_guess", gv_guess, 16'h1234);
    check("entry_post_guess", post_guess, 16'h0000);
    check("entry_post_cnt", 16'(post_cnt), 16'd0);
    check("entry_guess_now", guess, 16'h0000);

    // Edit path: duplicate, backspace, early enter.
    de0 = de_cnt;
    gv0 = gv_cnt;
    press(4'd1); press(4'd1);
    check("edit_dup_count", 16'(de_cnt - de0), 16'd1);
    check("edit_dup_guess", guess, 16'h1000);
    check("edit_dup_cnt", 16'(digit_cnt), 16'd1);
    press(4'd2);
    check("edit_two_guess", guess, 16'h1200);
    press(4'ha);
    check("edit_bs_guess", guess, 16'h1000);
    check("edit_bs_cnt", 16'(digit_cnt), 16'd1);
    press(4'hb);
    check("edit_early_enter", 16'(gv_cnt - gv0), 16'd0);
    press(4'ha); press(4'ha);
    check("edit_clear_cnt", 16'(digit_cnt), 16'd0);
    check("edit_clear_guess", guess, 16'h0000);

    // Overflow and unused keys.
    de0 = de_cnt;
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
    check("ovf_guess", guess, 16'h9876);
    check("ovf_cnt", 16'(digit_cnt), 16'd4);
    check("ovf_no_dup", 16'(de_cnt - de0), 16'd0);
    press(4'hc); press(4'hf);
    check("unused_guess", guess, 16'h9876);
    check("unused_cnt", 16'(digit_cnt), 16'd4);
    check("unused_code", 16'(key_code), 16'hf);
    gv0 = gv_cnt;
    press(4'hb);
    check("ovf_gv_guess", gv_guess, 16'h9876);
    check("ovf_gv_count", 16'(gv_cnt - gv0), 16'd1);

    // Asynchronous reset mid-entry.
    press(4'd1); press(4'd2); press(4'd3);
    check("pre_rst_cnt", 16'(digit_cnt), 16'd3);
    check("pre_rst_guess", guess, 16'h1230);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_guess", guess, 16'h0000);
    check("rst_cnt", 16'(digit_cnt), 16'd0);
    check("rst_key_code", 16'(key_code), 16'd0);
    check("rst_pulses", 16'({key_valid, guess_valid, dup_err}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0, 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
